s1_serial_tx: RTL

- Transmit end of the serial register-bank transfer link.
- Reads the 8 words of register bank RB1 in turn and serializes each as a 21-bit frame on the sen/sd pair: 3-bit address, MSB first, then 18-bit data, MSB first.
- Frames go to the S2 receive end, which rebuilds RB2.
- Asserts S1_done after the last frame has been shifted out.

---
 rtl/link_pkg.sv | 25 ++
 rtl/s1_serial_tx_if.sv | 30 +++
 rtl/s1_piso.sv | 36 +++
 rtl/s1_serial_tx.sv | 103 ++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the RB1 -> RB2 serial register-bank link.
// Used by both the S1 transmit end and the S2 receive end.
package link_pkg;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 18;
  localparam int NUM_WORDS = 8;
  localparam int FRAME_LEN = ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } link_state_e;

  function automatic logic [FRAME_LEN-1:0] make_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/s1_serial_tx_if.sv
// RB1 read port plus sen/sd serial pair of the transmit end.
// master = transmitter side, slave = register bank / receiver side.
interface s1_serial_tx_if import link_pkg::*;;

  logic              RB1_RW;
  logic [ADDR_W-1:0] RB1_A;
  logic [DATA_W-1:0] RB1_Q;
  logic              sen;
  logic              sd;
  logic              S1_done;

  modport master (
    output RB1_RW,
    output RB1_A,
    input  RB1_Q,
    output sen,
    output sd,
    output S1_done
  );

  modport slave (
    input  RB1_RW,
    input  RB1_A,
    output RB1_Q,
    input  sen,
    input  sd,
    input  S1_done
  );

endinterface

// File: rtl/s1_piso.sv
// Parallel-in/serial-out frame register, MSB first.
// Zeros shift in behind the frame, so the output idles low between frames.
module s1_piso import link_pkg::*; #(
  parameter int W = FRAME_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_en_i,
  input  logic [W-1:0] data_i,
  output logic         ser_o
);

  logic [W-1:0] shift_q;
  logic [W-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = data_i;
    end else if (shift_en_i) begin
      shift_d = {shift_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign ser_o = shift_q[W-1];

endmodule

// File: rtl/s1_serial_tx.sv
// Transmit end of the serial register-bank link: reads RB1 word by word
// and sends each as a {addr, data} frame on sen/sd, then raises S1_done.
//
// state | meaning
// FETCH | RB1_A presented, waiting one cycle for RB1_Q
// LOAD  | RB1_Q valid; frame captured on the next edge, sen falls
// SHIFT | one frame bit per cycle, sen low
// DONE  | all words sent, outputs parked until reset
module s1_serial_tx import link_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  s1_serial_tx_if.master       bus
);

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  link_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sen_q, sen_d;
  logic              done_q, done_d;
  logic              piso_load;
  logic              piso_shift;
  logic              piso_ser;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      addr_q  <= '0;
      sen_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sen_q   <= sen_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    sen_d      = sen_q;
    done_d     = done_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        piso_load = 1'b1;
        sen_d     = 1'b0;
        cnt_d     = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The shift on the final edge empties the register, dropping sd to 0
        piso_shift = 1'b1;
        if (cnt_q == LAST_BIT) begin
          sen_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  s1_piso #(
    .W (FRAME_LEN)
  ) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load_i     (piso_load),
    .shift_en_i (piso_shift),
    .data_i     (make_frame(addr_q, bus.RB1_Q)),
    .ser_o      (piso_ser)
  );

  assign bus.RB1_RW  = 1'b1;
  assign bus.RB1_A   = addr_q;
  assign bus.sen     = sen_q;
  assign bus.sd      = piso_ser;
  assign bus.S1_done = done_q;

endmodule
